// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel MM:SS timer.
// Holds the channel FSM state encoding, the BCD digit limits, the time
// field width and a helper that clamps a loaded BCD value into legal digits.
package timer_pkg;

  localparam int TIME_W  = 16;
  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] ONES_MAX     = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSE   = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  // Clamp each digit of {min_tens,min_ones,sec_tens,sec_ones} to its ceiling.
  function automatic logic [TIME_W-1:0] sat_time(input logic [TIME_W-1:0] v,
                                                 input logic [DIGIT_W-1:0] mt_max);
    logic [DIGIT_W-1:0] mt, mo, st, so;
    mt = (v[15:12] > mt_max)       ? mt_max       : v[15:12];
    mo = (v[11:8]  > ONES_MAX)     ? ONES_MAX     : v[11:8];
    st = (v[7:4]   > SEC_TENS_MAX) ? SEC_TENS_MAX : v[7:4];
    so = (v[3:0]   > ONES_MAX)     ? ONES_MAX     : v[3:0];
    return {mt, mo, st, so};
  endfunction

endpackage

// File: rtl/bcd_time_step.sv
// Combinational one-second step of an MM:SS BCD value.
// Ports:
//   cur  - current {min_tens,min_ones,sec_tens,sec_ones}
//   up   - 1 = add one second, 0 = subtract one second
//   nxt  - stepped value; wraps at 00:00 / MIN_TENS_MAX9:59
module bcd_time_step
  import timer_pkg::*;
#(
  parameter int MIN_TENS_MAX = 9
) (
  input  logic [TIME_W-1:0] cur,
  input  logic              up,
  output logic [TIME_W-1:0] nxt
);

  localparam logic [DIGIT_W-1:0] MT_MAX = DIGIT_W'(MIN_TENS_MAX);

  logic [DIGIT_W-1:0] mt, mo, st, so;

  always_comb begin
    mt = cur[15:12];
    mo = cur[11:8];
    st = cur[7:4];
    so = cur[3:0];
    if (up) begin
      if (so < ONES_MAX) so = so + 4'd1;
      else begin
        so = 4'd0;
        if (st < SEC_TENS_MAX) st = st + 4'd1;
        else begin
          st = 4'd0;
          if (mo < ONES_MAX) mo = mo + 4'd1;
          else begin
            mo = 4'd0;
            mt = (mt < MT_MAX) ? mt + 4'd1 : 4'd0;
          end
        end
      end
    end else begin
      if (so != 4'd0) so = so - 4'd1;
      else begin
        so = ONES_MAX;
        if (st != 4'd0) st = st - 4'd1;
        else begin
          st = SEC_TENS_MAX;
          if (mo != 4'd0) mo = mo - 4'd1;
          else begin
            mo = ONES_MAX;
            mt = (mt != 4'd0) ? mt - 4'd1 : MT_MAX;
          end
        end
      end
    end
    nxt = {mt, mo, st, so};
  end

endmodule

// File: rtl/multi_timer.sv
// Independent MM:SS BCD count-down / count-up timer channels sharing one
// 1 Hz tick.
// Ports:
//   clk, reset_n          - clock, async active-low reset
//   pulse_1Hz             - one-clk count tick shared by all channels
//   load, load_value      - per-channel load strobe and BCD value (16 bits/ch)
//   start, stop, clear    - per-channel command strobes
//   count_up              - per-channel direction, sampled at load
//   auto_reload           - per-channel restart-on-expiry level
//   time_out              - per-channel current BCD time (16 bits/ch)
//   running, done         - per-channel RUN indication, sticky expiry flag
//   done_pulse            - per-channel one-clk expiry strobe
//
// Channel FSM:
//   state      | meaning
//   IDLE       | loaded or cleared, waiting for start
//   RUN        | counting on pulse_1Hz
//   PAUSE      | stopped, time held, start resumes
//   EXPIRED    | reached terminal value without auto_reload; load/clear exit
module multi_timer
  import timer_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int MIN_TENS_MAX = 9
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       pulse_1Hz,
  input  logic [CHANNELS-1:0]        load,
  input  logic [TIME_W*CHANNELS-1:0] load_value,
  input  logic [CHANNELS-1:0]        start,
  input  logic [CHANNELS-1:0]        stop,
  input  logic [CHANNELS-1:0]        clear,
  input  logic [CHANNELS-1:0]        count_up,
  input  logic [CHANNELS-1:0]        auto_reload,
  output logic [TIME_W*CHANNELS-1:0] time_out,
  output logic [CHANNELS-1:0]        running,
  output logic [CHANNELS-1:0]        done,
  output logic [CHANNELS-1:0]        done_pulse
);

  localparam logic [DIGIT_W-1:0] MT_MAX = DIGIT_W'(MIN_TENS_MAX);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [1:0]        state;
    logic [TIME_W-1:0] cur;
    logic [TIME_W-1:0] rld;
    logic [TIME_W-1:0] nxt;
    logic [TIME_W-1:0] load_sat;
    logic              mode_up;
    logic              done_r;
    logic              pulse_r;
    logic              at_term;
    logic              nxt_term;
    logic              stop_ok;
    logic              start_ok;

    assign load_sat = sat_time(load_value[TIME_W*g +: TIME_W], MT_MAX);
    assign at_term  = mode_up ? (cur == rld) : (cur == '0);
    assign nxt_term = mode_up ? (nxt == rld) : (nxt == '0);

    // A command that does not apply in the current state is ignored and
    // lets the next-lower-priority command take the edge.
    assign stop_ok  = stop[g] && (state == ST_RUN);
    assign start_ok = start[g] && ((state == ST_IDLE) || (state == ST_PAUSE)) && !at_term;

    bcd_time_step #(.MIN_TENS_MAX(MIN_TENS_MAX)) u_step (
      .cur (cur),
      .up  (mode_up),
      .nxt (nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state   <= ST_IDLE;
        cur     <= '0;
        rld     <= '0;
        mode_up <= 1'b0;
        done_r  <= 1'b0;
        pulse_r <= 1'b0;
      end else begin
        pulse_r <= 1'b0;
        if (clear[g]) begin
          cur    <= '0;
          rld    <= '0;
          done_r <= 1'b0;
          state  <= ST_IDLE;
        end else if (load[g]) begin
          rld     <= load_sat;
          mode_up <= count_up[g];
          cur     <= count_up[g] ? '0 : load_sat;
          done_r  <= 1'b0;
          state   <= ST_IDLE;
        end else if (stop_ok) begin
          state <= ST_PAUSE;
        end else if (start_ok) begin
          state  <= ST_RUN;
          done_r <= 1'b0;
        end else if (pulse_1Hz && (state == ST_RUN)) begin
          // Terminal value while still in RUN only happens after an
          // auto-reload expiry: this tick restarts the count.
          if (at_term) begin
            cur <= mode_up ? '0 : rld;
          end else begin
            cur <= nxt;
            if (nxt_term) begin
              done_r  <= 1'b1;
              pulse_r <= 1'b1;
              if (!auto_reload[g]) state <= ST_EXPIRED;
            end
          end
        end
      end
    end

    assign time_out[TIME_W*g +: TIME_W] = cur;
    assign running[g]    = (state == ST_RUN);
    assign done[g]       = done_r;
    assign done_pulse[g] = pulse_r;
  end

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer (2 channels, 99:59 ceiling).
module tb_multi_timer;

  logic        clk;
  logic        reset_n;
  logic        pulse_1Hz;
  logic [1:0]  load, start, stop, clear, count_up, auto_reload;
  logic [31:0] load_value;
  logic [31:0] time_out;
  logic [1:0]  running, done, done_pulse;

  multi_timer #(.CHANNELS(2), .MIN_TENS_MAX(9)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pulse_1Hz   (pulse_1Hz),
    .load        (load),
    .load_value  (load_value),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .count_up    (count_up),
    .auto_reload (auto_reload),
    .time_out    (time_out),
    .running     (running),
    .done        (done),
    .done_pulse  (done_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [1:0]  ld, st, sp, cl, cu, ar;
    logic        tk;
    logic [31:0] lv, et;
    logic [1:0]  er, ed, ep;
  } vec_t;

  typedef struct {
    string       nm;
    logic [31:0] t;
    logic [1:0]  r, d, p;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[18];

  function automatic vec_t mk(input string nm, input logic [1:0] ld, st, sp, cl, cu, ar,
                              input logic tk, input logic [31:0] lv, et,
                              input logic [1:0] er, ed, ep);
    vec_t v;
    v.nm = nm; v.ld = ld; v.st = st; v.sp = sp; v.cl = cl; v.cu = cu; v.ar = ar;
    v.tk = tk; v.lv = lv; v.et = et; v.er = er; v.ed = ed; v.ep = ep;
    return v;
  endfunction

  // Independent seconds -> MM:SS BCD model
  function automatic logic [15:0] to_bcd(input int s);
    int m, sc;
    m  = s / 60;
    sc = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic step(input string nm, input logic [1:0] ld, st, sp, cl, cu, ar,
                      input logic tk, input logic [31:0] lv, et,
                      input logic [1:0] er, ed, ep);
    exp_t e;
    @(negedge clk);
    load = ld; start = st; stop = sp; clear = cl; count_up = cu; auto_reload = ar;
    pulse_1Hz = tk; load_value = lv;
    e.nm = nm; e.t = et; e.r = er; e.d = ed; e.p = ep;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      chk({e.nm, ".time"},    time_out,           e.t);
      chk({e.nm, ".running"}, {30'd0, running},   {30'd0, e.r});
      chk({e.nm, ".done"},    {30'd0, done},      {30'd0, e.d});
      chk({e.nm, ".pulse"},   {30'd0, done_pulse}, {30'd0, e.p});
    end
    load = '0; start = '0; stop = '0; clear = '0; pulse_1Hz = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    step(v.nm, v.ld, v.st, v.sp, v.cl, v.cu, v.ar, v.tk, v.lv, v.et, v.er, v.ed, v.ep);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".time"},    time_out,                  32'h0);
    chk({nm, ".running"}, {30'd0, running},          32'h0);
    chk({nm, ".done"},    {30'd0, done},             32'h0);
    chk({nm, ".pulse"},   {30'd0, done_pulse},       32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    logic [15:0] v;
    reset_n = 1'b0; pulse_1Hz = 1'b0;
    load = '0; start = '0; stop = '0; clear = '0; count_up = '0; auto_reload = '0;
    load_value = '0;
    #3;
    chk_zero("reset");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    //               name          ld     st     sp     cl     cu     ar     tk   lv            exp time      run    done   pulse
    tbl[0]  = mk("sat_load",   2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0000_9A7C, 32'h0000_9959, 2'b00, 2'b00, 2'b00);
    tbl[1]  = mk("sat_start",  2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0,         32'h0000_9959, 2'b01, 2'b00, 2'b00);
    tbl[2]  = mk("sat_tick",   2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 32'h0,         32'h0000_9958, 2'b01, 2'b00, 2'b00);
    tbl[3]  = mk("stop",       2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 0, 32'h0,         32'h0000_9958, 2'b00, 2'b00, 2'b00);
    tbl[4]  = mk("pause_tick", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 32'h0,         32'h0000_9958, 2'b00, 2'b00, 2'b00);
    tbl[5]  = mk("resume",     2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0,         32'h0000_9958, 2'b01, 2'b00, 2'b00);
    tbl[6]  = mk("clear_tick", 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1, 32'h0,         32'h0000_0000, 2'b00, 2'b00, 2'b00);
    tbl[7]  = mk("start_zero", 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0,         32'h0000_0000, 2'b00, 2'b00, 2'b00);
    tbl[8]  = mk("load_up0",   2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 0, 32'h0,         32'h0000_0000, 2'b00, 2'b00, 2'b00);
    tbl[9]  = mk("start_up0",  2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 0, 32'h0,         32'h0000_0000, 2'b00, 2'b00, 2'b00);
    tbl[10] = mk("load_both",  2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0003_0100, 32'h0003_0100, 2'b00, 2'b00, 2'b00);
    tbl[11] = mk("start_both", 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0,         32'h0003_0100, 2'b11, 2'b00, 2'b00);
    tbl[12] = mk("both_t1",    2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 32'h0,         32'h0002_0059, 2'b11, 2'b00, 2'b00);
    tbl[13] = mk("both_t2",    2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 32'h0,         32'h0001_0058, 2'b11, 2'b00, 2'b00);
    tbl[14] = mk("ch1_expire", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 32'h0,         32'h0000_0057, 2'b01, 2'b10, 2'b10);
    tbl[15] = mk("ch1_hold",   2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 32'h0,         32'h0000_0056, 2'b01, 2'b10, 2'b00);
    tbl[16] = mk("exp_start",  2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0,         32'h0000_0056, 2'b01, 2'b10, 2'b00);
    tbl[17] = mk("ch1_clear",  2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 0, 32'h0,         32'h0000_0056, 2'b01, 2'b00, 2'b00);

    for (int i = 0; i < 18; i++) run_vec(tbl[i]);

    // 01:00 down, 60 ticks to expiry
    step("dn_clr",   2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 0, 32'h0,    32'h0, 2'b00, 2'b00, 2'b00);
    step("dn_load",  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0100, 32'h0000_0100, 2'b00, 2'b00, 2'b00);
    step("dn_start", 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0,    32'h0000_0100, 2'b01, 2'b00, 2'b00);
    for (int k = 1; k <= 60; k++)
      step("dn_tick", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 32'h0, {16'h0, to_bcd(60 - k)},
           (k < 60) ? 2'b01 : 2'b00, (k == 60) ? 2'b01 : 2'b00, (k == 60) ? 2'b01 : 2'b00);
    step("dn_extra", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 32'h0, 32'h0, 2'b00, 2'b01, 2'b00);
    step("dn_start_exp", 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0, 32'h0, 2'b00, 2'b01, 2'b00);

    // 00:05 up
    step("up_load",  2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 0, 32'h0005, 32'h0, 2'b00, 2'b00, 2'b00);
    step("up_start", 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 0, 32'h0,    32'h0, 2'b01, 2'b00, 2'b00);
    for (int k = 1; k <= 5; k++)
      step("up_tick", 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1, 32'h0, {16'h0, to_bcd(k)},
           (k < 5) ? 2'b01 : 2'b00, (k == 5) ? 2'b01 : 2'b00, (k == 5) ? 2'b01 : 2'b00);
    for (int k = 0; k < 2; k++)
      step("up_extra", 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1, 32'h0, 32'h0000_0005, 2'b00, 2'b01, 2'b00);

    // 00:02 down with auto-reload: period of 3 ticks
    step("ar_load",  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 32'h0002, 32'h0000_0002, 2'b00, 2'b00, 2'b00);
    step("ar_start", 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 0, 32'h0,    32'h0000_0002, 2'b01, 2'b00, 2'b00);
    for (int k = 1; k <= 9; k++) begin
      m = k % 3;
      v = (m == 0) ? 16'h0002 : 16'(2 - m);
      step("ar_tick", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1, 32'h0, {16'h0, v},
           2'b01, (k >= 2) ? 2'b01 : 2'b00, (m == 2) ? 2'b01 : 2'b00);
    end
    step("ar_stop",   2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 0, 32'h0, 32'h0000_0002, 2'b00, 2'b01, 2'b00);
    step("ar_restart",2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 0, 32'h0, 32'h0000_0002, 2'b01, 2'b00, 2'b00);
    step("ar_clear",  2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00);

    // stop+start+tick on ch0 with a ch1 load on the same edge
    step("pr_load",  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0010, 32'h0000_0010, 2'b00, 2'b00, 2'b00);
    step("pr_start", 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0,    32'h0000_0010, 2'b01, 2'b00, 2'b00);
    step("pr_mix",   2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1, 32'h0123_0000, 32'h0123_0010, 2'b00, 2'b00, 2'b00);
    step("pr_tick",  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 32'h0,    32'h0123_0010, 2'b00, 2'b00, 2'b00);

    // async reset mid-count at 03:27
    step("rs_load",  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0328, 32'h0123_0328, 2'b00, 2'b00, 2'b00);
    step("rs_start", 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0,    32'h0123_0328, 2'b01, 2'b00, 2'b00);
    step("rs_tick",  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 32'h0,    32'h0123_0327, 2'b01, 2'b00, 2'b00);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("rs_async");
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++)
      step("rs_post_tick", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00);
    step("rs_post_start", 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
